hazard_scheduler: RTL and testbench
===================================

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter MUL_LAT, default 4: busy cycles of the multi-cycle unit for mult/multu (valid range 1-63).
REQ-002 Parameter DIV_LAT, default 32: busy cycles of the multi-cycle unit for div/divu (valid range 1-63).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ID_Rs, ID_Rt  in  5 each  source register fields of the instruction in ID.
REQ-006 ID_PCSrc  in  2  decoder PC source for the ID instruction: 00 sequential, 01 j/jal, 10 jr/jalr.
REQ-007 ID_MulDiv  in  2  ID instruction class: 00 none, 01 mult/multu, 10 div/divu, 11 mfhi/mflo/mthi/mtlo.
REQ-008 EX_MemRead  in  1  instruction in EX is a load.
REQ-009 EX_Rt  in  5  destination register of the instruction in EX.
REQ-010 EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
REQ-011 PC_Write  out  1  PC update enable.
REQ-012 IF_ID_Write  out  1  IF/ID register write enable.
REQ-013 IF_ID_Flush  out  1  IF/ID register cleared to a bubble.
REQ-014 ID_EX_Flush  out  1  ID/EX register loaded with a bubble (all control zero).
REQ-015 MD_Busy  out  1  multi-cycle unit occupied.
REQ-016 MD_Done  out  1  one-cycle pulse: HI/LO result written this cycle.
REQ-017 StallCount  out  16  saturating count of stall cycles.

Function
REQ-018 Load-use hazard (LU) SHALL be asserted when EX_MemRead=1, EX_Rt!=0, and EX_Rt equals ID_Rs or ID_Rt.
REQ-019 Jr hazard (JR) SHALL be asserted when ID_PCSrc=10, EX_MemRead=1, EX_Rt!=0, and EX_Rt==ID_Rs.
REQ-020 MD hazard (MH) SHALL be asserted when ID_MulDiv!=00 and MD_Busy=1 and MD_Done=0.
REQ-021 Stall = (LU or JR or MH) and not EX_BranchTaken.
REQ-022 On Stall, the block SHALL drive PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, and IF_ID_Flush=0.
REQ-023 On EX_BranchTaken=1, the block SHALL drive PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, and ID_EX_Flush=1, overriding all stalls and jumps.
REQ-024 With no stall and no taken branch, ID_PCSrc!=00 SHALL give IF_ID_Flush=1 and ID_EX_Flush=0, with PC_Write and IF_ID_Write equal to 1.
REQ-025 Otherwise, the outputs SHALL be PC_Write=1, IF_ID_Write=1, and both flushes 0.
REQ-026 Outputs in REQ-021 to REQ-025 are combinational from the inputs and the current state (no added latency).
REQ-027 FSM states: IDLE and BUSY; a 6-bit down-counter Cnt runs alongside.
REQ-028 Issue = ID_MulDiv in {01,10} and not Stall and not EX_BranchTaken.
REQ-029 IDLE with Issue: next state BUSY, with Cnt loaded to MUL_LAT-1 (for 01) or DIV_LAT-1 (for 10).
REQ-030 IDLE without Issue: next state IDLE.
REQ-031 BUSY with Cnt!=0: Cnt decrements by 1.
REQ-032 BUSY with Cnt==0: MD_Done=1; next state is BUSY (reloaded per REQ-029) if Issue, else IDLE.
REQ-033 MD_Busy SHALL equal 1 exactly while in BUSY, so an operation occupies exactly LAT consecutive cycles after the issue cycle.
REQ-034 Back-to-back issue is legal: in the MD_Done cycle MH is 0, so a dependent mfhi/mult in ID proceeds without a bubble.
REQ-035 An issue squashed by EX_BranchTaken in the same cycle SHALL NOT start the unit.
REQ-036 A taken branch SHALL NOT abort an operation already in BUSY.
REQ-037 StallCount SHALL increment by 1 on every cycle with Stall=1 and saturate at 16'hFFFF (no wrap-around).

Reset
REQ-038 While reset=1 at a clock edge: state goes to IDLE, Cnt=0, StallCount=0, MD_Busy=0, MD_Done=0.
REQ-039 Reset SHALL abort any operation in progress.
REQ-040 The combinational outputs (PC_Write, IF_ID_Write, flushes) SHALL follow REQ-021 to REQ-025 from the reset state, independent of the reset level.

Verification
REQ-041 Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, StallCount+1; repeat with EX_Rt=0 -> no stall.
REQ-042 Branch priority: load-use stall conditions plus EX_BranchTaken=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, StallCount unchanged.
REQ-043 Multiply then mflo: issue 01 at cycle T, hold ID_MulDiv=11 -> stall cycles T+1..T+3; MD_Done=1 at T+4; no stall at T+4; IDLE at T+5.
REQ-044 Divide back-to-back: issue 10, then issue 01 in the MD_Done cycle -> MD_Busy stays 1 continuously for DIV_LAT+MUL_LAT cycles, with no bubble.
REQ-045 Reset mid-divide at busy cycle 10 -> next cycle MD_Busy=0, StallCount=0, no MD_Done pulse.
REQ-046 Saturation: hold LU for 65540 cycles -> StallCount=16'hFFFF, no wrap to 0.

Source files
------------

// File: rtl/hazard_scheduler.sv
`timescale 1ns/1ps
// Pipeline hazard scheduler: load-use / jr / multi-cycle-unit stalls, branch and jump
// flushes, the HI/LO unit occupancy FSM and a saturating stall-cycle counter.
module hazard_scheduler #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic [1:0]  ID_PCSrc,
   input  logic [1:0]  ID_MulDiv,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_Rt,
   input  logic        EX_BranchTaken,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Flush,
   output logic        MD_Busy,
   output logic        MD_Done,
   output logic [15:0] StallCount
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_JR  = 2'b10;
   localparam logic [1:0] MD_NONE = 2'b00;
   localparam logic [1:0] MD_MUL  = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;

   logic [0:0]  state;
   logic [5:0]  cnt;
   logic [15:0] stall_cnt;

   logic        lu_hazard;
   logic        jr_hazard;
   logic        md_hazard;
   logic        stall;
   logic        issue;
   logic [5:0]  load_val;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign MD_Busy    = (state == BUSY);
   assign MD_Done    = MD_Busy && (cnt == 6'd0);
   assign StallCount = stall_cnt;

   assign lu_hazard = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
   assign jr_hazard = (ID_PCSrc == PC_JR) && EX_MemRead && (EX_Rt != 5'd0) &&
                      (EX_Rt == ID_Rs);
   // The completion cycle releases dependent HI/LO users without a bubble.
   assign md_hazard = (ID_MulDiv != MD_NONE) && MD_Busy && !MD_Done;
   assign stall     = (lu_hazard || jr_hazard || md_hazard) && !EX_BranchTaken;
   assign issue     = ((ID_MulDiv == MD_MUL) || (ID_MulDiv == MD_DIV)) &&
                      !stall && !EX_BranchTaken;
   assign load_val  = (ID_MulDiv == MD_MUL) ? MUL_LOAD : DIV_LOAD;

   always_comb begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      if (EX_BranchTaken) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (stall) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
      end else if (ID_PCSrc != PC_SEQ) begin
         IF_ID_Flush = 1'b1;
      end
   end

   // A taken branch never touches the FSM once BUSY; only reset aborts an operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 6'd0;
         stall_cnt <= 16'd0;
      end else begin
         if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
         case (state)
            IDLE: begin
               if (issue) begin
                  state <= BUSY;
                  cnt   <= load_val;
               end
            end
            BUSY: begin
               if (cnt != 6'd0) begin
                  cnt <= cnt - 6'd1;
               end else if (issue) begin
                  cnt <= load_val;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 6'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for hazard_scheduler: directed steps queue expected outputs,
// an independent monitor compares them against the DUT each cycle.
module tb_hazard_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  ID_Rs = '0, ID_Rt = '0, EX_Rt = '0;
   logic [1:0]  ID_PCSrc = '0, ID_MulDiv = '0;
   logic        EX_MemRead = 1'b0, EX_BranchTaken = 1'b0;
   logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Busy, MD_Done;
   logic [15:0] StallCount;

   typedef struct {
      string       nm;
      logic [5:0]  o;    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Busy, MD_Done}
      logic [15:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   hazard_scheduler #(.MUL_LAT(4), .DIV_LAT(32)) dut (
      .clk(clk), .reset(reset),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_PCSrc(ID_PCSrc), .ID_MulDiv(ID_MulDiv),
      .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken),
      .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Flush(ID_EX_Flush), .MD_Busy(MD_Busy), .MD_Done(MD_Done),
      .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] RUN   = 6'b110000;
   localparam logic [5:0] STALL = 6'b000100;
   localparam logic [5:0] BRF   = 6'b111100;
   localparam logic [5:0] JMP   = 6'b111000;

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] pc,
                        input logic [1:0] md, input logic mr, input logic [4:0] er,
                        input logic br);
      @(negedge clk);
      ID_Rs = rs; ID_Rt = rt; ID_PCSrc = pc; ID_MulDiv = md;
      EX_MemRead = mr; EX_Rt = er; EX_BranchTaken = br;
   endtask

   task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] pc,
                       input logic [1:0] md, input logic mr, input logic [4:0] er,
                       input logic br, input string nm, input logic [5:0] eo,
                       input logic [15:0] esc);
      exp_t e;
      drive(rs, rt, pc, md, mr, er, br);
      e.nm = nm; e.o = eo; e.sc = esc;
      exp_q.push_back(e);
   endtask

   task automatic idle(input string nm, input logic [5:0] eo, input logic [15:0] esc);
      step(5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0, nm, eo, esc);
   endtask

   // Monitor: compares every queued expectation against the live outputs.
   initial begin
      exp_t e;
      logic [5:0] act;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Busy, MD_Done};
            total++;
            if (act === e.o && StallCount === e.sc) begin
               passed++;
            end else begin
               $display("FAIL %s: outputs=%b count=%h, required outputs=%b count=%h",
                        e.nm, act, StallCount, e.o, e.sc);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      idle("reset_state", RUN, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      idle("idle", RUN, 16'd0);
      step(5'd5, 5'd0, 2'b00, 2'b00, 1'b1, 5'd5, 1'b0, "lu_rs", STALL, 16'd0);
      step(5'd0, 5'd7, 2'b00, 2'b00, 1'b1, 5'd7, 1'b0, "lu_rt", STALL, 16'd1);
      step(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd0, 1'b0, "lu_r0", RUN, 16'd2);
      step(5'd5, 5'd0, 2'b00, 2'b00, 1'b1, 5'd5, 1'b1, "br_prio", BRF, 16'd2);
      step(5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 5'd0, 1'b0, "jump", JMP, 16'd2);
      step(5'd9, 5'd0, 2'b10, 2'b00, 1'b1, 5'd9, 1'b0, "jr_haz", STALL, 16'd2);
      step(5'd9, 5'd0, 2'b10, 2'b00, 1'b0, 5'd9, 1'b0, "jr_ok", JMP, 16'd3);

      // multiply then mflo
      step(5'd0, 5'd0, 2'b00, 2'b01, 1'b0, 5'd0, 1'b0, "mul_issue", RUN, 16'd3);
      step(5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 5'd0, 1'b0, "mflo_t1", STALL | 6'b000010, 16'd3);
      step(5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 5'd0, 1'b0, "mflo_t2", STALL | 6'b000010, 16'd4);
      step(5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 5'd0, 1'b0, "mflo_t3", STALL | 6'b000010, 16'd5);
      step(5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 5'd0, 1'b0, "mflo_done", RUN | 6'b000011, 16'd6);
      idle("mul_idle", RUN, 16'd6);

      // issue squashed by a taken branch must not start the unit
      step(5'd0, 5'd0, 2'b00, 2'b01, 1'b0, 5'd0, 1'b1, "squash", BRF, 16'd6);
      idle("squash_chk", RUN, 16'd6);

      // divide, then multiply issued in the completion cycle
      step(5'd0, 5'd0, 2'b00, 2'b10, 1'b0, 5'd0, 1'b0, "div_issue", RUN, 16'd6);
      for (int i = 1; i <= 31; i++) begin
         if (i == 5)
            step(5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 5'd0, 1'b1, "div_branch", BRF | 6'b000010, 16'd6);
         else
            idle($sformatf("div_busy%0d", i), RUN | 6'b000010, 16'd6);
      end
      step(5'd0, 5'd0, 2'b00, 2'b01, 1'b0, 5'd0, 1'b0, "div_done_mul", RUN | 6'b000011, 16'd6);
      for (int i = 1; i <= 3; i++) idle($sformatf("b2b_mul%0d", i), RUN | 6'b000010, 16'd6);
      idle("b2b_mul_done", RUN | 6'b000011, 16'd6);
      idle("b2b_idle", RUN, 16'd6);

      // reset at busy cycle 10 of a divide
      step(5'd0, 5'd0, 2'b00, 2'b10, 1'b0, 5'd0, 1'b0, "div2_issue", RUN, 16'd6);
      for (int i = 1; i <= 9; i++) idle($sformatf("div2_busy%0d", i), RUN | 6'b000010, 16'd6);
      idle("div2_busy10", RUN | 6'b000010, 16'd6);
      reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
      exp_q.push_back('{nm: "post_reset", o: RUN, sc: 16'd0});
      for (int i = 0; i < 30; i++) idle($sformatf("no_done%0d", i), RUN, 16'd0);

      // saturation
      for (int i = 0; i < 65540; i++) drive(5'd3, 5'd0, 2'b00, 2'b00, 1'b1, 5'd3, 1'b0);
      step(5'd3, 5'd0, 2'b00, 2'b00, 1'b1, 5'd3, 1'b0, "sat_stall", STALL, 16'hFFFF);
      idle("sat_hold", RUN, 16'hFFFF);

      @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         total++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
